// File: rtl/aileron_cmd_slew.sv
// Aileron command slew stage: walks the sign-magnitude angle bus toward the
// latched target one magnitude step at a time. Optional clamp: AILERON_MAG_LIMIT_EN.
module aileron_cmd_slew #(
  parameter int STEP_DIV      = 4,
  parameter int NEUTRAL_DWELL = 2,
  parameter int MAG_LIMIT     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_ang,
  output logic       cmd_ready,
  output logic [3:0] ang,
  output logic       busy,
  output logic       at_target
);

  typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (NEUTRAL_DWELL > 1) ? $clog2(NEUTRAL_DWELL) : 1;

  state_t        state;
  logic [3:0]    target;
  logic [PW-1:0] presc;
  logic [DW-1:0] dwell_cnt;

  logic       accept;
  logic [3:0] cmd_target;
  logic [3:0] tgt_eff;
  logic       step_fire;
  logic [3:0] step_ang;
  logic       to_dwell;

  // Magnitude 0 always maps to 4'b0000 so the bus never carries "negative zero".
  function automatic logic [3:0] normalize(input logic [3:0] a);
    logic [2:0] m;
    m = a[2:0];
`ifdef AILERON_MAG_LIMIT_EN
    if (m > 3'(MAG_LIMIT)) m = 3'(MAG_LIMIT);
`endif
    if (m == 3'd0) return 4'b0000;
    return {a[3], m};
  endfunction

`ifndef AILERON_MAG_LIMIT_EN
  logic unused_mag_limit;
  assign unused_mag_limit = |3'(MAG_LIMIT);
`endif

  // Handshake: a command transfers on any rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready drops only while dwelling at neutral.
  assign cmd_ready  = (state != DWELL);
  assign busy       = (state != IDLE);
  assign at_target  = (state == IDLE) && (ang == target);
  assign accept     = cmd_valid & cmd_ready;
  assign cmd_target = normalize(cmd_ang);
  assign tgt_eff    = accept ? cmd_target : target;
  assign step_fire  = (presc == PW'(STEP_DIV - 1));

  // One magnitude step toward tgt_eff; reversals always pass through neutral.
  always_comb begin
    step_ang = ang;
    to_dwell = 1'b0;
    if (ang[2:0] == 3'd0) begin
      if (tgt_eff[2:0] != 3'd0) step_ang = {tgt_eff[3], 3'd1};
    end else if (ang[3] == tgt_eff[3]) begin
      if (ang[2:0] < tgt_eff[2:0])      step_ang = {ang[3], ang[2:0] + 3'd1};
      else if (ang[2:0] > tgt_eff[2:0]) step_ang = {ang[3], ang[2:0] - 3'd1};
    end else if (ang[2:0] > 3'd1) begin
      step_ang = {ang[3], ang[2:0] - 3'd1};
    end else begin
      step_ang = 4'b0000;
      to_dwell = (tgt_eff[2:0] != 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ang       <= 4'b0000;
      target    <= 4'b0000;
      presc     <= '0;
      dwell_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target <= cmd_target;
            if (cmd_target != ang) begin
              state <= MOVE;
              presc <= '0;
            end
          end
        end
        MOVE: begin
          if (accept) target <= cmd_target;
          if (step_fire) begin
            presc <= '0;
            ang   <= step_ang;
            if (step_ang == tgt_eff) begin
              state <= IDLE;
            end else if (to_dwell) begin
              state     <= DWELL;
              dwell_cnt <= '0;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        DWELL: begin
          if (dwell_cnt == DW'(NEUTRAL_DWELL - 1)) begin
            state     <= MOVE;
            presc     <= '0;
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aileron_cmd_slew.sv
// Bench for aileron_cmd_slew: table of timed expectations per command group,
// checked through a scoreboard queue, plus an asynchronous reset sequence.
module tb_aileron_cmd_slew;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [3:0] cmd_ang;
  logic       cmd_ready;
  logic [3:0] ang;
  logic       busy;
  logic       at_target;

  aileron_cmd_slew #(.STEP_DIV(4), .NEUTRAL_DWELL(2), .MAG_LIMIT(6)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ang(cmd_ang),
    .cmd_ready(cmd_ready), .ang(ang), .busy(busy), .at_target(at_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         grp;
    int         t;
    logic [3:0] ang;
    logic       busy;
    logic       ready;
    logic       at;
  } vec_t;

  typedef struct {
    logic [3:0] cmd;
    int         ncyc;
    int         inj_t;
    int         inj_len;
    logic [3:0] inj_cmd;
  } grp_t;

  vec_t vecs[$];
  grp_t grps[$];

  // scoreboard
  logic [6:0] exp_q[$];
  int         exp_t_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic add_vec(input int g, input int t, input logic [3:0] a,
                         input logic b, input logic r, input logic at);
    vec_t v;
    v.grp = g; v.t = t; v.ang = a; v.busy = b; v.ready = r; v.at = at;
    vecs.push_back(v);
  endtask

  task automatic add_grp(input logic [3:0] cmd, input int ncyc, input int inj_t,
                         input int inj_len, input logic [3:0] inj_cmd);
    grp_t g;
    g.cmd = cmd; g.ncyc = ncyc; g.inj_t = inj_t; g.inj_len = inj_len; g.inj_cmd = inj_cmd;
    grps.push_back(g);
  endtask

  task automatic check_now(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {ang, busy, cmd_ready, at_target};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got ang=%b busy=%b ready=%b at=%b, expected ang=%b busy=%b ready=%b at=%b",
               name, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_group(input int g);
    grp_t gr;
    gr = grps[g];
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        exp_q.push_back({vecs[i].ang, vecs[i].busy, vecs[i].ready, vecs[i].at});
        exp_t_q.push_back(vecs[i].t);
      end
    end
    cmd_valid = 1'b1;
    cmd_ang   = gr.cmd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int t = 1; t <= gr.ncyc; t++) begin
      if (t >= gr.inj_t && t < gr.inj_t + gr.inj_len) begin
        cmd_valid = 1'b1;
        cmd_ang   = gr.inj_cmd;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      while (exp_t_q.size() > 0 && exp_t_q[0] == t) begin
        void'(exp_t_q.pop_front());
        check_now($sformatf("grp%0d_t%0d", g, t), exp_q.pop_front());
      end
    end
    if (exp_q.size() > 0) begin
      n_err += exp_q.size();
      $display("FAIL grp%0d_unchecked: got %0d pending, expected 0", g, exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  initial begin
    // group 0: 0000 -> 0011
    add_grp(4'b0011, 14, 0, 0, 4'b0000);
    add_vec(0, 1,  4'b0000, 1, 1, 0);
    add_vec(0, 3,  4'b0000, 1, 1, 0);
    add_vec(0, 4,  4'b0001, 1, 1, 0);
    add_vec(0, 8,  4'b0010, 1, 1, 0);
    add_vec(0, 11, 4'b0010, 1, 1, 0);
    add_vec(0, 12, 4'b0011, 0, 1, 1);
    add_vec(0, 14, 4'b0011, 0, 1, 1);
    // group 1: 0011 -> 1010 through neutral dwell
    add_grp(4'b1010, 24, 0, 0, 4'b0000);
    add_vec(1, 4,  4'b0010, 1, 1, 0);
    add_vec(1, 8,  4'b0001, 1, 1, 0);
    add_vec(1, 11, 4'b0001, 1, 1, 0);
    add_vec(1, 12, 4'b0000, 1, 0, 0);
    add_vec(1, 13, 4'b0000, 1, 0, 0);
    add_vec(1, 14, 4'b0000, 1, 1, 0);
    add_vec(1, 17, 4'b0000, 1, 1, 0);
    add_vec(1, 18, 4'b1001, 1, 1, 0);
    add_vec(1, 21, 4'b1001, 1, 1, 0);
    add_vec(1, 22, 4'b1010, 0, 1, 1);
    add_vec(1, 24, 4'b1010, 0, 1, 1);
    // group 2: 1010 -> 0000, reaches neutral without dwell
    add_grp(4'b0000, 10, 0, 0, 4'b0000);
    add_vec(2, 4,  4'b1001, 1, 1, 0);
    add_vec(2, 8,  4'b0000, 0, 1, 1);
    add_vec(2, 10, 4'b0000, 0, 1, 1);
    // group 3: negative zero at neutral stays idle
    add_grp(4'b1000, 4, 0, 0, 4'b0000);
    add_vec(3, 1,  4'b0000, 0, 1, 1);
    add_vec(3, 3,  4'b0000, 0, 1, 1);
    // group 4: 0000 -> 0010
    add_grp(4'b0010, 9, 0, 0, 4'b0000);
    add_vec(4, 4,  4'b0001, 1, 1, 0);
    add_vec(4, 8,  4'b0010, 0, 1, 1);
    // group 5: 0010 -> negative zero, no dwell
    add_grp(4'b1000, 10, 0, 0, 4'b0000);
    add_vec(5, 4,  4'b0001, 1, 1, 0);
    add_vec(5, 8,  4'b0000, 0, 1, 1);
    add_vec(5, 9,  4'b0000, 0, 1, 1);
    // group 6: 0101 retargeted to 0001 mid-move (prescaler not restarted)
    add_grp(4'b0101, 11, 6, 1, 4'b0001);
    add_vec(6, 4,  4'b0001, 1, 1, 0);
    add_vec(6, 6,  4'b0001, 1, 1, 0);
    add_vec(6, 7,  4'b0001, 1, 1, 0);
    add_vec(6, 8,  4'b0001, 0, 1, 1);
    add_vec(6, 10, 4'b0001, 0, 1, 1);
    // group 7: 0001 -> 1001, command offered during dwell must be ignored
    add_grp(4'b1001, 13, 5, 2, 4'b0011);
    add_vec(7, 4,  4'b0000, 1, 0, 0);
    add_vec(7, 5,  4'b0000, 1, 0, 0);
    add_vec(7, 6,  4'b0000, 1, 1, 0);
    add_vec(7, 9,  4'b0000, 1, 1, 0);
    add_vec(7, 10, 4'b1001, 0, 1, 1);
    add_vec(7, 12, 4'b1001, 0, 1, 1);
    // group 8: 0000 -> 1111, full-scale ramp (clamped when the limit is enabled)
    add_grp(4'b1111, 30, 0, 0, 4'b0000);
    add_vec(8, 4,  4'b1001, 1, 1, 0);
    add_vec(8, 20, 4'b1101, 1, 1, 0);
`ifdef AILERON_MAG_LIMIT_EN
    add_vec(8, 24, 4'b1110, 0, 1, 1);
    add_vec(8, 28, 4'b1110, 0, 1, 1);
`else
    add_vec(8, 24, 4'b1110, 1, 1, 0);
    add_vec(8, 28, 4'b1111, 0, 1, 1);
    add_vec(8, 30, 4'b1111, 0, 1, 1);
`endif

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ang   = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_now("reset_idle", {4'b0000, 1'b0, 1'b1, 1'b1});

    for (int g = 0; g < 8; g++) run_group(g);

    // asynchronous reset in the middle of a reversal from 1001
    cmd_valid = 1'b1;
    cmd_ang   = 4'b0011;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("pre_reset_busy", {4'b1001, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", {4'b0000, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_now("post_reset_idle", {4'b0000, 1'b0, 1'b1, 1'b1});

    run_group(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
